// File: rtl/param_stream_counter.sv
// Parametrised arithmetic-sequence generator with a valid/ready stream output.
// Supports up/down counting, run-once or wrap-around, and clamps any overshoot to the limit.
module param_stream_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic             cfg_dir,
    input  logic             cfg_wrap,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             xfer;
    logic             at_limit;

    assign sum      = {1'b0, count_q} + {1'b0, step_q};
    assign diff     = {1'b0, count_q} - {1'b0, step_q};
    assign xfer     = valid_q && out_ready;
    assign at_limit = (count_q == limit_q);

    assign out_data  = count_q;
    assign out_valid = valid_q;
    assign out_last  = (state_q == RUN) && at_limit;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            start_q <= '0;
            limit_q <= '0;
            step_q  <= '0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            start_q <= start_d;
            limit_q <= limit_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next-state and output logic; clear overrides everything else
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        start_d = start_q;
        limit_d = limit_q;
        step_d  = step_q;
        dir_d   = dir_q;
        wrap_d  = wrap_q;

        if (clear) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        start_d = cfg_start;
                        limit_d = cfg_limit;
                        step_d  = (cfg_step == '0) ? WIDTH'(1) : cfg_step;
                        dir_d   = cfg_dir;
                        wrap_d  = cfg_wrap;
                        state_d = RUN;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        // A start already beyond the limit is clamped onto it
                        if ((!cfg_dir && cfg_start > cfg_limit) ||
                            (cfg_dir && cfg_start < cfg_limit)) begin
                            count_d = cfg_limit;
                            ovf_d   = 1'b1;
                        end else begin
                            count_d = cfg_start;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (at_limit) begin
                            if (wrap_q) begin
                                count_d = start_q;
                            end else begin
                                state_d = IDLE;
                                valid_d = 1'b0;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end else if (!dir_q) begin
                            if (sum[WIDTH] || (sum[WIDTH-1:0] > limit_q)) begin
                                count_d = limit_q;
                                ovf_d   = 1'b1;
                            end else begin
                                count_d = sum[WIDTH-1:0];
                            end
                        end else begin
                            if (diff[WIDTH] || (diff[WIDTH-1:0] < limit_q)) begin
                                count_d = limit_q;
                                ovf_d   = 1'b1;
                            end else begin
                                count_d = diff[WIDTH-1:0];
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_stream_counter.sv
// Self-checking bench for param_stream_counter: directed cases plus random configurations,
// compared against a sequence model built from plain integer arithmetic.
module tb_param_stream_counter;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic             start;
    logic [WIDTH-1:0] cfg_start;
    logic [WIDTH-1:0] cfg_limit;
    logic [WIDTH-1:0] cfg_step;
    logic             cfg_dir;
    logic             cfg_wrap;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             ovf;

    int tests = 0;
    int fails = 0;
    bit ovf_model = 1'b0;

    param_stream_counter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start),
        .cfg_start(cfg_start), .cfg_limit(cfg_limit), .cfg_step(cfg_step),
        .cfg_dir(cfg_dir), .cfg_wrap(cfg_wrap),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        ovf_model = 1'b0;
        check("clear_valid", 32'(out_valid), 32'd0);
        check("clear_busy", 32'(busy), 32'd0);
        check("clear_ovf", 32'(ovf), 32'd0);
    endtask

    // Launch one sequence and follow it for n transfers (stop mode: the whole pass).
    // mode 0: ready always high, 1: ready high every third cycle, 2: random ready.
    task automatic run_seq(input int s, input int l, input int st, input bit d, input bit w,
                           input int n, input int mode);
        int vals[$];
        bit clp[$];
        int v, nx, stp, idx, xfers, cyc, total;
        bit c, rdy;
        stp = (st == 0) ? 1 : st;
        v = s;
        c = 1'b0;
        if ((!d && s > l) || (d && s < l)) begin
            v = l;
            c = 1'b1;
        end
        forever begin
            vals.push_back(v);
            clp.push_back(c);
            if (v == l) break;
            nx = d ? v - stp : v + stp;
            c = 1'b0;
            if ((!d && nx > l) || (d && nx < l)) begin
                nx = l;
                c = 1'b1;
            end
            v = nx;
        end
        total = w ? n : vals.size();

        cfg_start = WIDTH'(s);
        cfg_limit = WIDTH'(l);
        cfg_step  = WIDTH'(st);
        cfg_dir   = d;
        cfg_wrap  = w;
        start     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;

        idx = 0;
        xfers = 0;
        cyc = 0;
        while (xfers < total && cyc < 5000) begin
            ovf_model = ovf_model | clp[idx];
            check("run_valid", 32'(out_valid), 32'd1);
            check("run_busy", 32'(busy), 32'd1);
            check("run_data", 32'(out_data), 32'(vals[idx]));
            check("run_last", 32'(out_last), 32'(vals[idx] == l));
            check("run_ovf", 32'(ovf), 32'(ovf_model));
            check("run_done", 32'(done), 32'd0);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 3) == 0;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) begin
                xfers++;
                idx = (idx + 1) % vals.size();
            end
        end
        check("run_budget", 32'(cyc < 5000), 32'd1);
        out_ready = 1'b0;

        if (!w) begin
            check("end_valid", 32'(out_valid), 32'd0);
            check("end_busy", 32'(busy), 32'd0);
            check("end_done", 32'(done), 32'd1);
            check("end_ovf", 32'(ovf), 32'(ovf_model));
            @(negedge clk);
            check("end_done_pulse", 32'(done), 32'd0);
        end else begin
            do_clear();
        end
    endtask

    initial begin
        int rs, rl, rst_v, rn, rm;
        bit rd, rw;
        reset = 1'b1;
        clear = 1'b0;
        start = 1'b0;
        cfg_start = '0;
        cfg_limit = '0;
        cfg_step = '0;
        cfg_dir = 1'b0;
        cfg_wrap = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_seq(2, 11, 3, 1'b0, 1'b0, 0, 0);
        run_seq(0, 10, 4, 1'b0, 1'b0, 0, 0);
        do_clear();
        run_seq(5, 1, 2, 1'b1, 1'b1, 8, 0);
        run_seq(0, 3, 1, 1'b0, 1'b0, 0, 1);
        run_seq(3, 6, 0, 1'b0, 1'b0, 0, 0);
        run_seq(7, 7, 1, 1'b0, 1'b0, 0, 0);
        run_seq(200, 100, 1, 1'b0, 1'b0, 0, 0);
        run_seq(250, 255, 10, 1'b0, 1'b0, 0, 0);
        do_clear();
        run_seq(0, 255, 1, 1'b0, 1'b1, 300, 0);

        // Start while running is ignored and clear mid-sequence discards it
        cfg_start = 8'd2; cfg_limit = 8'd11; cfg_step = 8'd3;
        cfg_dir = 1'b0; cfg_wrap = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        cfg_start = 8'd100;
        @(negedge clk);
        start = 1'b0;
        check("ign_start_data", 32'(out_data), 32'd5);
        @(negedge clk);
        out_ready = 1'b0;
        check("clr_at8", 32'(out_data), 32'd8);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        ovf_model = 1'b0;
        check("clr_valid", 32'(out_valid), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_ovf", 32'(ovf), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        check("clr_hold", 32'(out_data), 32'd8);
        @(negedge clk);
        check("clr_no_done", 32'(done), 32'd0);

        // Asynchronous reset between clock edges
        cfg_start = 8'd1; cfg_limit = 8'd50; cfg_step = 8'd60;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        #1;
        reset = 1'b0;
        ovf_model = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("arst_no_done", 32'(done), 32'd0);
        run_seq(9, 1, 3, 1'b1, 1'b0, 0, 1);

        // Random configurations against the model
        for (int i = 0; i < 12; i++) begin
            rs = int'($urandom_range(0, 255));
            rl = int'($urandom_range(0, 255));
            rst_v = int'($urandom_range(0, 40));
            rd = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            rm = int'($urandom_range(0, 2));
            if (rw) begin
                rd = (rs > rl);
                rn = int'($urandom_range(1, 40));
            end else begin
                rn = 0;
            end
            run_seq(rs, rl, rst_v, rd, rw, rn, rm);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_stream_counter.md
Name: param_stream_counter

Overview:
Parametrised successor of the sanity counter. It generates a configurable arithmetic sequence (start, step, limit, up/down) and emits it as a stream with valid/ready handshake. It supports run-once and wrap-around modes. It sits in hwpe-stream test and sanity infrastructure as an index/address source driving streamers under backpressure.

Parameters:
WIDTH, 8, bit width of count, start, limit and step.

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous abort; returns to IDLE, clears ovf
start  in  1  launch sequence (sampled in IDLE only)
cfg_start  in  WIDTH  first value
cfg_limit  in  WIDTH  final value (inclusive)
cfg_step  in  WIDTH  increment magnitude; 0 treated as 1
cfg_dir  in  1  0 = count up, 1 = count down
cfg_wrap  in  1  0 = stop after limit, 1 = reload start and continue
out_data  out  WIDTH  current value
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts
out_last  out  1  high with out_valid when out_data == limit
busy  out  1  high in RUN
done  out  1  one-cycle pulse after last transfer in stop mode
ovf  out  1  sticky: a step overshot limit and was clamped

Behaviour:
- Reset (async, active-high): state IDLE; out_data=0, out_valid=0, out_last=0, busy=0, done=0, ovf=0.
- FSM states IDLE and RUN.
- IDLE: on start=1 (and clear=0), latch start, limit, step, dir and wrap into internal registers. count <= cfg_start; go to RUN.
- Latency: start in cycle N gives out_valid=1 in cycle N+1.
- Start-past-limit check at latch: if up and start>limit, or down and start<limit, then count <= limit and ovf <= 1.
- RUN: out_valid=1, busy=1. A transfer occurs when out_valid && out_ready.
- Backpressure: without a transfer, out_data, out_last and state are held stable.
- Transfer with count != limit: next = count ± step, computed at WIDTH+1 bits.
  - Up: if carry or sum > limit, clamp next to limit and set ovf.
  - Down: if borrow or diff < limit, clamp next to limit and set ovf.
  - Limit is therefore always emitted exactly once per pass.
- Transfer with count == limit (out_last=1):
  - wrap=0: go to IDLE; out_valid=0 the next cycle; done=1 for exactly that one cycle.
  - wrap=1: count <= latched start and stay in RUN. No bubble: the next cycle's out_valid=1 with the start value.
- start while in RUN is ignored. Config inputs are ignored outside the latch cycle.
- clear (sync) has priority over start and any transfer. Next cycle: IDLE, out_valid=0, busy=0, ovf=0, done=0. out_data keeps its last value. Outstanding sequence is discarded.
- start=limit: single transfer with out_last=1.
- Full-range wrap, e.g. up 0..255 step 1 at WIDTH=8: no overshoot, ovf stays 0.
- ovf is cleared only by reset or clear. A new start does not clear it.
- Reset asserted mid-sequence: immediate return to reset values, with no done pulse.
- out_last is combinational from registered count and state (registered outputs only otherwise).

Test Plan:
- Up, stop mode: start=2, step=3, limit=11, out_ready=1 → sequence 2,5,8,11; out_last only on 11; done pulse on the cycle after 11; ovf=0.
- Overshoot clamp: start=0, step=4, limit=10 → 0,4,8,10; ovf=1 after the 8→10 step.
- Down with wrap: dir=1, start=5, step=2, limit=1, wrap=1, 8 transfers → 5,3,1,5,3,1,5,3; no bubbles; busy stays high.
- Backpressure: up 0..3, out_ready toggled 1,0,0,1,... → each value held stable while ready=0; values are never skipped or duplicated.
- Boundaries:
  - step=0 behaves as step=1.
  - start=limit=7 → single beat with out_last.
  - up start=200, limit=100 → single beat 100, ovf=1.
  - WIDTH=8, start=250, step=10, limit=255 → 250,255, ovf=1.
- Abort/reset: clear mid-sequence at value 8 → IDLE next cycle, ovf=0, no done. Async reset pulse between clock edges → outputs go to 0 immediately. A following start runs a correct fresh sequence.
